// File: rtl/rbus_pkg.sv
// Shared definitions for the instruction read bus: line geometry, the
// responder's state encoding and its base response latency.
package rbus_pkg;

  localparam int BLK_LEN  = 4;                  // words per line
  localparam int LANE_W   = 32;                 // bits per word lane
  localparam int LINE_W   = BLK_LEN * LANE_W;   // bits per returned line
  localparam int RBUS_LAT = 6;                  // request-to-rvalid cycles, excluding wait cycles

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_READ  = ST_READ,
    S_DRAIN = ST_DRAIN,
    S_RESP  = ST_RESP
  } rbus_state_e;

endpackage

// File: rtl/rbus_line_responder_if.sv
// Instruction read bus between the ICache/uncached fetch path (master)
// and the memory-side line responder (slave).
interface rbus_line_responder_if;
  import rbus_pkg::*;

  logic                mem_rrdy;
  logic [BLK_LEN-1:0]  mem_ren;
  logic [31:0]         mem_raddr;
  logic                mem_rvalid;
  logic [LINE_W-1:0]   mem_rdata;

  modport master (
    input  mem_rrdy, mem_rvalid, mem_rdata,
    output mem_ren, mem_raddr
  );

  modport slave (
    output mem_rrdy, mem_rvalid, mem_rdata,
    input  mem_ren, mem_raddr
  );

endinterface

// File: rtl/rbus_line_responder.sv
// Memory-side responder: accepts one block-read at a time, walks four
// consecutive RAM words (optionally after a fixed wait), and returns them
// as a single registered 128-bit line with a one-cycle rvalid pulse.
module rbus_line_responder #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0,
  parameter int BLK_LEN     = rbus_pkg::BLK_LEN
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst,
  rbus_line_responder_if.slave      bus,
  output logic                      ram_en,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic [rbus_pkg::LANE_W-1:0] ram_rdata
);
  import rbus_pkg::*;

  rbus_state_e                      state;
  logic [7:0]                       wait_cnt;
  logic [1:0]                       lane;
  logic [ADDR_W-1:0]                base;
  logic [BLK_LEN-1:0]               mask;
  logic [BLK_LEN-2:0][LANE_W-1:0]   lane_buf;
  logic [1:0]                       prev_lane;
  logic [LANE_W-1:0]                cap_word;
  logic                             unused_raddr;

  // Byte offset and address bits above the RAM range play no part.
  assign unused_raddr = ^{bus.mem_raddr[31:ADDR_W+2], bus.mem_raddr[1:0]};

  // RAM data arriving now belongs to the lane addressed one cycle earlier;
  // in DRAIN that is the last lane. Masked-off lanes are forced to zero.
  assign prev_lane = (state == S_DRAIN) ? 2'(BLK_LEN - 1) : lane - 2'd1;
  assign cap_word  = mask[prev_lane] ? ram_rdata : '0;

  // Request FSM with registered bus and RAM outputs.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      lane           <= '0;
      base           <= '0;
      mask           <= '0;
      lane_buf       <= '0;
      ram_en         <= 1'b0;
      ram_addr       <= '0;
      bus.mem_rrdy   <= 1'b1;
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= '0;
    end else begin
      bus.mem_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mem_ren != '0) begin
            base         <= bus.mem_raddr[ADDR_W+1:2];
            mask         <= bus.mem_ren;
            lane         <= '0;
            bus.mem_rrdy <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 8'(WAIT_CYCLES - 1);
            end else begin
              // Lane 0 address goes out in the very next cycle.
              state    <= S_READ;
              ram_en   <= bus.mem_ren[0];
              ram_addr <= bus.mem_raddr[ADDR_W+1:2];
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= S_READ;
            ram_en   <= mask[0];
            ram_addr <= base;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        S_READ: begin
          if (lane != '0)
            lane_buf[prev_lane] <= cap_word;
          if (lane == 2'(BLK_LEN - 1)) begin
            state  <= S_DRAIN;
            ram_en <= 1'b0;
          end else begin
            // Address wraps silently at the top of the RAM.
            lane     <= lane + 2'd1;
            ram_en   <= mask[lane + 2'd1];
            ram_addr <= base + ADDR_W'(lane) + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          bus.mem_rdata  <= {cap_word, lane_buf};
          bus.mem_rvalid <= 1'b1;
          state          <= S_RESP;
        end
        S_RESP: begin
          bus.mem_rrdy <= 1'b1;
          lane         <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbus_line_responder.sv
// Bench for rbus_line_responder: two instances (no wait, 3 wait cycles)
// share one stimulus stream; a timing/data model predicts every output on
// every cycle, and directed cases pin the model with literal values.
module tb_rbus_line_responder;
  import rbus_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [3:0]  ren;
  logic [31:0] raddr;

  rbus_line_responder_if bus0 ();
  rbus_line_responder_if bus1 ();
  assign bus0.mem_ren   = ren;
  assign bus0.mem_raddr = raddr;
  assign bus1.mem_ren   = ren;
  assign bus1.mem_raddr = raddr;

  logic        ram_en0, ram_en1;
  logic [13:0] ram_addr0, ram_addr1;
  logic [31:0] ram_q0, ram_q1;

  rbus_line_responder #(.ADDR_W(14), .WAIT_CYCLES(0), .BLK_LEN(4)) dut0 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus0),
    .ram_en(ram_en0), .ram_addr(ram_addr0), .ram_rdata(ram_q0));

  rbus_line_responder #(.ADDR_W(14), .WAIT_CYCLES(3), .BLK_LEN(4)) dut1 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus1),
    .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_rdata(ram_q1));

  always #5 cpu_clk = ~cpu_clk;

  // inst_word_ram: 1-cycle synchronous read, word[i] = A000_0000 + i
  always @(posedge cpu_clk) begin
    if (ram_en0) ram_q0 <= 32'hA000_0000 + {18'd0, ram_addr0};
    if (ram_en1) ram_q1 <= 32'hA000_0000 + {18'd0, ram_addr1};
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] exp_line(input int unsigned b, input logic [3:0] m);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (m[k]) r[32*k +: 32] = 32'hA000_0000 + ((b + k) % 16384);
    return r;
  endfunction

  // Model state: acceptance cycle, base word, mask and last returned line per DUT.
  int           cyc = 0;
  int           acc   [2] = '{-1, -1};
  int unsigned  mbase [2];
  logic [3:0]   mmask [2];
  logic [127:0] mline [2] = '{128'd0, 128'd0};

  // Compare every output of both DUTs against the model once per cycle.
  always @(negedge cpu_clk) begin
    for (int i = 0; i < 2; i++) begin
      int w, k;
      bit busy, rv, en;
      logic rrdy_a, rv_a, en_a;
      logic [127:0] rd_a;
      logic [13:0] ad_a;
      w      = (i == 0) ? 0 : 3;
      rrdy_a = (i == 0) ? bus0.mem_rrdy   : bus1.mem_rrdy;
      rv_a   = (i == 0) ? bus0.mem_rvalid : bus1.mem_rvalid;
      rd_a   = (i == 0) ? bus0.mem_rdata  : bus1.mem_rdata;
      en_a   = (i == 0) ? ram_en0   : ram_en1;
      ad_a   = (i == 0) ? ram_addr0 : ram_addr1;
      if (cpu_rst) begin
        chk($sformatf("d%0d_rst_rrdy", i), 128'(rrdy_a), 128'd1);
        chk($sformatf("d%0d_rst_rvalid", i), 128'(rv_a), 128'd0);
        chk($sformatf("d%0d_rst_rdata", i), rd_a, 128'd0);
        chk($sformatf("d%0d_rst_ram_en", i), 128'(en_a), 128'd0);
        chk($sformatf("d%0d_rst_ram_addr", i), 128'(ad_a), 128'd0);
        acc[i]   = -1;
        mline[i] = '0;
      end else begin
        busy = (acc[i] >= 0) && (cyc >= acc[i] + 1) && (cyc <= acc[i] + 6 + w);
        rv   = (acc[i] >= 0) && (cyc == acc[i] + 6 + w);
        if (rv) mline[i] = exp_line(mbase[i], mmask[i]);
        k  = cyc - (acc[i] + 1 + w);
        en = (acc[i] >= 0) && (k >= 0) && (k < 4) ? mmask[i][k] : 1'b0;
        chk($sformatf("d%0d_rrdy", i), 128'(rrdy_a), 128'(!busy));
        chk($sformatf("d%0d_rvalid", i), 128'(rv_a), 128'(rv));
        chk($sformatf("d%0d_rdata", i), rd_a, mline[i]);
        chk($sformatf("d%0d_ram_en", i), 128'(en_a), 128'(en));
        if (en)
          chk($sformatf("d%0d_ram_addr", i), 128'(ad_a), 128'((mbase[i] + k) % 16384));
        if (!busy && ren != 4'd0) begin
          acc[i]   = cyc;
          mbase[i] = raddr[31:2];
          mmask[i] = ren;
        end
      end
    end
    cyc++;
  end

  // One request in isolation; reports rvalid latency of each DUT.
  task automatic do_req(input logic [3:0] m, input logic [31:0] a, output int l0, output int l1);
    l0 = -1;
    l1 = -1;
    @(posedge cpu_clk); #2; ren = m; raddr = a;
    @(posedge cpu_clk); #2; ren = '0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge cpu_clk);
      if (bus0.mem_rvalid && l0 < 0) l0 = j;
      if (bus1.mem_rvalid && l1 < 0) l1 = j;
    end
  endtask

  // Directed cases, then randomized traffic.
  initial begin
    int l0, l1, p0, p1;
    cpu_rst = 1'b1;
    ren     = '0;
    raddr   = '0;
    repeat (3) @(posedge cpu_clk);
    #2 cpu_rst = 1'b0;
    #1;
    chk("init_rrdy", 128'(bus0.mem_rrdy), 128'd1);
    chk("init_rdata", bus0.mem_rdata, 128'd0);

    // Aligned ICache request
    do_req(4'hF, 32'h0000_0040, l0, l1);
    chk("aligned_lat_w0", 128'(l0), 128'd6);
    chk("aligned_lat_w3", 128'(l1), 128'd9);
    chk("aligned_line", bus0.mem_rdata,
        {32'hA000_0013, 32'hA000_0012, 32'hA000_0011, 32'hA000_0010});
    chk("aligned_line_w3", bus1.mem_rdata,
        {32'hA000_0013, 32'hA000_0012, 32'hA000_0011, 32'hA000_0010});

    // Uncached unaligned request
    do_req(4'hF, 32'h0000_0048, l0, l1);
    chk("uncached_lane0", 128'(bus0.mem_rdata[31:0]), 128'h A000_0012);
    chk("uncached_lane3", 128'(bus0.mem_rdata[127:96]), 128'h A000_0015);

    // Lane mask
    do_req(4'b0101, 32'h0000_0040, l0, l1);
    chk("mask_lat", 128'(l0), 128'd6);
    chk("mask_line", bus0.mem_rdata, {32'h0, 32'hA000_0012, 32'h0, 32'hA000_0010});

    // Wrap at the top of the RAM, with wait cycles
    do_req(4'hF, 32'h0000_FFF8, l0, l1);
    chk("wrap_lat_w3", 128'(l1), 128'd9);
    chk("wrap_line_w3", bus1.mem_rdata,
        {32'hA000_0001, 32'hA000_0000, 32'hA000_3FFF, 32'hA000_3FFE});

    // Back-to-back: request held for 8 cycles
    p0 = 0; p1 = 0;
    @(posedge cpu_clk); #2; ren = 4'hF; raddr = 32'h0000_0040;
    repeat (8) begin
      @(negedge cpu_clk);
      p0 += int'(bus0.mem_rvalid);
      p1 += int'(bus1.mem_rvalid);
    end
    @(posedge cpu_clk); #2; ren = '0;
    repeat (20) begin
      @(negedge cpu_clk);
      p0 += int'(bus0.mem_rvalid);
      p1 += int'(bus1.mem_rvalid);
    end
    chk("b2b_pulses_w0", 128'(p0), 128'd2);
    chk("b2b_pulses_w3", 128'(p1), 128'd1);

    // Reset during READ lane 2 of the no-wait instance
    @(posedge cpu_clk); #2; ren = 4'hF; raddr = 32'h0000_0040;
    @(posedge cpu_clk); #2; ren = '0;
    @(posedge cpu_clk); #2;
    @(posedge cpu_clk); #2; cpu_rst = 1'b1;
    #1;
    chk("midrst_rrdy", 128'(bus0.mem_rrdy), 128'd1);
    chk("midrst_ram_en", 128'(ram_en0), 128'd0);
    repeat (2) @(posedge cpu_clk);
    #2 cpu_rst = 1'b0;
    p0 = 0; p1 = 0;
    repeat (15) begin
      @(negedge cpu_clk);
      p0 += int'(bus0.mem_rvalid);
      p1 += int'(bus1.mem_rvalid);
    end
    chk("midrst_no_rvalid", 128'(p0 + p1), 128'd0);
    chk("midrst_rdata", bus0.mem_rdata, 128'd0);
    do_req(4'hF, 32'h0000_0048, l0, l1);
    chk("after_rst_lat", 128'(l0), 128'd6);
    chk("after_rst_line", bus0.mem_rdata,
        {32'hA000_0015, 32'hA000_0014, 32'hA000_0013, 32'hA000_0012});

    // Random traffic, checked by the per-cycle model
    for (int n = 0; n < 600; n++) begin
      @(posedge cpu_clk); #2;
      ren   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      raddr = ($urandom_range(0, 7) == 0) ? (32'h0000_FFF0 + 32'($urandom_range(0, 15)))
                                          : $urandom;
    end
    @(posedge cpu_clk); #2; ren = '0;
    repeat (15) @(posedge cpu_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
